music_sequencer: RTL and testbench

Parametrised song player for the audio path: holds NUM_SONGS note sequences in a write-loadable RAM, steps through the selected song at a fixed step rate, and drives a square-wave speaker pulse directly. It supersedes the fixed 64-note, always-looping player: adds song select, start/stop/loop control, rest and end-of-song codes, and a busy/done status toward the game controller.

---
 rtl/music_sequencer.sv | 159 +++++++++++++++
 tb/tb_music_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/music_sequencer.sv
// music_sequencer: plays note sequences from a write-loadable RAM and drives a square-wave speaker.
// Optional MUSIC_SEQ_GAP_EN: the last GAP_CYCLES of every step are silenced to articulate repeated notes.
module music_sequencer #(
    parameter int CLK_HZ        = 50_000_000,
    parameter int STEPS_PER_SEC = 8,
    parameter int SONG_DEPTH    = 64,
    parameter int NUM_SONGS     = 4,
    parameter int PERIOD_W      = 20,
    parameter int GAP_CYCLES    = (CLK_HZ / STEPS_PER_SEC) / 8,
    localparam int AW = $clog2(NUM_SONGS * SONG_DEPTH),
    localparam int SW = $clog2(NUM_SONGS),
    localparam int DW = $clog2(SONG_DEPTH)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_wr_en,
    input  logic [AW-1:0]       i_wr_addr,
    input  logic [PERIOD_W-1:0] i_wr_data,
    input  logic [SW-1:0]       i_song_sel,
    input  logic                i_loop,
    input  logic                i_start,
    input  logic                i_stop,
    output logic                o_pulse,
    output logic                o_busy,
    output logic [DW-1:0]       o_step,
    output logic                o_done
);

    localparam int STEP_CYCLES = CLK_HZ / STEPS_PER_SEC;
    localparam int TW          = $clog2(STEP_CYCLES);
    localparam logic [TW-1:0] STEP_LAST = TW'(STEP_CYCLES - 1);
    localparam logic [DW-1:0] STEP_MAX  = DW'(SONG_DEPTH - 1);
    localparam logic [31:0]   GAP_START = 32'(STEP_CYCLES - GAP_CYCLES);
`ifdef MUSIC_SEQ_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, FETCH, DECODE, PLAY} state_t;

    state_t              state, state_d;
    logic [PERIOD_W-1:0] mem [NUM_SONGS * SONG_DEPTH];
    logic [PERIOD_W-1:0] rd_data;
    logic [PERIOD_W-1:0] half_q;
    logic [PERIOD_W-1:0] tone_cnt;
    logic [TW-1:0]       step_timer;
    logic [DW-1:0]       step_q;
    logic [SW-1:0]       song_q;
    logic                loop_q, rest_q, pulse_q;
    logic                done_evt, restart, advance;
    logic                entry_end, step_last, in_gap;

    assign entry_end = (rd_data == '1);
    assign step_last = (step_timer == STEP_LAST);
    assign in_gap    = GAP_EN && ({{(32-TW){1'b0}}, step_timer} >= GAP_START);
    assign o_step    = step_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_d;
    end

    // NOTE: every variable assigned here gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_d  = state;
        done_evt = 1'b0;
        restart  = 1'b0;
        advance  = 1'b0;
        unique case (state)
            IDLE:   if (i_start && !i_stop) state_d = FETCH;
            FETCH:  state_d = DECODE;
            DECODE: begin
                if (!entry_end) begin
                    state_d = PLAY;
                end else if (loop_q && step_q != '0) begin
                    state_d = FETCH;
                    restart = 1'b1;
                end else begin
                    state_d  = IDLE;
                    done_evt = 1'b1;
                end
            end
            PLAY: begin
                if (step_last) begin
                    state_d = FETCH;
                    if (step_q != STEP_MAX) advance = 1'b1;
                    else if (loop_q)        restart = 1'b1;
                    else begin
                        state_d  = IDLE;
                        done_evt = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides any other transition, including a pending done.
        if (state != IDLE && i_stop) begin
            state_d  = IDLE;
            done_evt = 1'b0;
            restart  = 1'b0;
            advance  = 1'b0;
        end
    end

    always_comb begin
        o_busy  = (state != IDLE);
        o_pulse = pulse_q && (state == PLAY) && !in_gap;
    end

    // NOTE: the song RAM has no reset so it maps onto block RAM; contents survive i_rst.
    always_ff @(posedge i_clk) begin
        if (i_wr_en)         mem[i_wr_addr] <= i_wr_data;
        if (state == FETCH)  rd_data <= mem[{song_q, step_q}];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            song_q     <= '0;
            loop_q     <= 1'b0;
            step_q     <= '0;
            step_timer <= '0;
            tone_cnt   <= '0;
            half_q     <= '0;
            rest_q     <= 1'b1;
            pulse_q    <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_done <= done_evt;
            if (state == IDLE && state_d == FETCH) begin
                song_q <= i_song_sel;
                loop_q <= i_loop;
                step_q <= '0;
            end else if (restart) begin
                step_q <= '0;
            end else if (advance) begin
                step_q <= step_q + 1'b1;
            end
            // Timer restarts on every FETCH so each step spans exactly STEP_CYCLES.
            if (state_d == FETCH || state_d == IDLE) step_timer <= '0;
            else                                     step_timer <= step_timer + 1'b1;
            if (state == DECODE) begin
                half_q   <= rd_data;
                rest_q   <= (rd_data == '0);
                tone_cnt <= '0;
                pulse_q  <= 1'b0;
            end else if (state == PLAY && !rest_q && !in_gap) begin
                if (tone_cnt == half_q - 1'b1) begin
                    tone_cnt <= '0;
                    pulse_q  <= ~pulse_q;
                end else begin
                    tone_cnt <= tone_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_music_sequencer.sv
// Scoreboard bench for music_sequencer: a song-level model predicts every output change, a monitor compares.
module tb_music_sequencer;

    localparam int STEP  = 100;
    localparam int DEPTH = 8;
    localparam int SONGS = 2;
    localparam int PW    = 8;
    localparam int AW    = 4;
    localparam int SW    = 1;
    localparam int DW    = 3;
    localparam int GAP   = 12;
    localparam int END_VAL = 255;
`ifdef MUSIC_SEQ_GAP_EN
    localparam int GAP_START = STEP - GAP;
`else
    localparam int GAP_START = STEP;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [PW-1:0] wr_data = '0;
    logic [SW-1:0] song_sel = '0;
    logic          loop = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          pulse, busy, done;
    logic [DW-1:0] step;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ram_m[SONGS*DEPTH];
    int m_step = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int cyc;
        int sig;
        int val;
    } ev_t;
    ev_t exp_q[$];

    music_sequencer #(
        .CLK_HZ(1000), .STEPS_PER_SEC(10), .SONG_DEPTH(DEPTH), .NUM_SONGS(SONGS),
        .PERIOD_W(PW), .GAP_CYCLES(GAP)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_song_sel(song_sel), .i_loop(loop), .i_start(start), .i_stop(stop),
        .o_pulse(pulse), .o_busy(busy), .o_step(step), .o_done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Event encoding for reporting: cycle*100 + signal*10 + value (signals: 0 busy, 1 step, 2 done, 3 pulse).
    task automatic compare_ev(input int sig, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_change: got %0d expected no change", cyc*100 + sig*10 + val);
        end else begin
            e = exp_q.pop_front();
            check("output_event", cyc*100 + sig*10 + val, e.cyc*100 + e.sig*10 + e.val);
        end
    endtask

    logic          p_busy = 1'b0, p_done = 1'b0, p_pulse = 1'b0;
    logic [DW-1:0] p_step = '0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy  !== p_busy)  compare_ev(0, int'(busy));
            if (step  !== p_step)  compare_ev(1, int'(step));
            if (done  !== p_done)  compare_ev(2, int'(done));
            if (pulse !== p_pulse) compare_ev(3, int'(pulse));
        end
        p_busy  = busy;
        p_step  = step;
        p_done  = done;
        p_pulse = pulse;
    end

    // Song-level model: index i is the output level just after edge a+i.
    task automatic build_expect(input int song, input bit lp, input int a, input int stop_x, input int n);
        int  busy_v[], step_v[], done_v[], pulse_v[];
        int  t, stp, e;
        int  prev[4], cur[4];
        bit  fin;
        ev_t ev;
        busy_v = new[n]; step_v = new[n]; done_v = new[n]; pulse_v = new[n];
        for (int i = 0; i < n; i++) begin
            busy_v[i] = 0; step_v[i] = -1; done_v[i] = 0; pulse_v[i] = 0;
        end
        t = 0; stp = 0; fin = 1'b0;
        while (!fin && t < n) begin
            e = ram_m[song*DEPTH + stp];
            if (e == END_VAL) begin
                for (int k = 0; k < 2; k++) if (t + k < n) begin
                    busy_v[t+k] = 1; step_v[t+k] = stp;
                end
                if (lp && stp != 0) stp = 0;
                else begin
                    if (t + 2 < n) done_v[t+2] = 1;
                    fin = 1'b1;
                end
                t += 2;
            end else begin
                for (int k = 0; k < STEP; k++) if (t + k < n) begin
                    busy_v[t+k]  = 1;
                    step_v[t+k]  = stp;
                    pulse_v[t+k] = (e != 0 && k >= 2 && k < GAP_START && ((k - 2) / e) % 2 == 1) ? 1 : 0;
                end
                t += STEP;
                if (stp != DEPTH - 1) stp++;
                else if (lp) stp = 0;
                else begin
                    if (t < n) done_v[t] = 1;
                    fin = 1'b1;
                end
            end
        end
        for (int i = 1; i < n; i++) if (step_v[i] < 0) step_v[i] = step_v[i-1];
        if (stop_x > 0 && stop_x < n)
            for (int i = stop_x; i < n; i++) begin
                busy_v[i] = 0; pulse_v[i] = 0; done_v[i] = 0; step_v[i] = step_v[stop_x-1];
            end
        prev = '{0, m_step, 0, 0};
        for (int i = 0; i < n; i++) begin
            cur = '{busy_v[i], step_v[i], done_v[i], pulse_v[i]};
            for (int s = 0; s < 4; s++) if (cur[s] != prev[s]) begin
                ev.cyc = a + i; ev.sig = s; ev.val = cur[s];
                exp_q.push_back(ev);
            end
            prev = cur;
        end
        m_step = step_v[n-1];
    endtask

    task automatic wr(input int addr, input int data);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = AW'(addr); wr_data = PW'(data);
        @(negedge clk);
        wr_en = 1'b0;
        ram_m[addr] = data;
    endtask

    // stop_x / poke_x: relative edge at which i_stop / a stray i_start is sampled (0 = none).
    task automatic run_song(input int song, input bit lp, input int stop_x, input int poke_x, input int n);
        int a;
        @(negedge clk);
        a = cyc + 1;
        build_expect(song, lp, a, stop_x, n);
        song_sel = SW'(song); loop = lp; start = 1'b1;
        @(negedge clk);
        start = 1'b0; song_sel = ~song_sel; loop = ~lp;
        while (cyc < a + n - 1) begin
            stop  = (stop_x > 0 && cyc == a + stop_x - 1);
            start = (poke_x > 0 && cyc == a + poke_x - 1);
            @(negedge clk);
        end
        stop = 1'b0; start = 1'b0;
        #1;
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        int sg, sx, r;
        bit lp;
        repeat (3) @(negedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_pulse", int'(pulse), 0);
        check("reset_step", int'(step), 0);
        check("reset_done", int'(done), 0);
        rst = 1'b0;
        mon_en = 1'b1;

        wr(0, 5); wr(1, 0); wr(2, 10); wr(3, END_VAL);
        for (int i = 4; i < DEPTH; i++) wr(i, 0);
        for (int i = 0; i < DEPTH; i++) wr(DEPTH + i, 4);

        run_song(0, 1'b0, 0, 50, 320);
        run_song(0, 1'b1, 650, 0, 700);
        run_song(1, 1'b0, 0, 0, 820);
        wr(DEPTH, END_VAL);
        run_song(1, 1'b1, 0, 0, 20);

        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("start_stop_idle_busy", int'(busy), 0);

        // Reset in the middle of a high tone phase of step 2.
        run_song(0, 1'b0, 0, 0, 215);
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_pulse", int'(pulse), 0);
        check("async_rst_step", int'(step), 0);
        check("async_rst_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        m_step = 0;
        #1;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);
        run_song(0, 1'b0, 0, 0, 320);

        for (int round = 0; round < 6; round++) begin
            for (int j = 0; j < DEPTH; j++) begin
                r = $urandom_range(0, 9);
                wr(DEPTH + j, (r == 0) ? 0 : (r == 1) ? END_VAL : $urandom_range(1, 20));
            end
            sg = $urandom_range(0, 1);
            lp = 1'($urandom_range(0, 1));
            sx = (lp || $urandom_range(0, 1) == 1) ? $urandom_range(5, 850) : 0;
            run_song(sg, lp, sx, 0, 900);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
